// File: rtl/attn_softmax_if.sv
// Score-tile / probability-tile handshake between the attention datapath and attn_softmax.
// The master drives a score tile with I_VLD; the slave returns O_PROB with an O_VLD pulse.
interface attn_softmax_if #(
  parameter int D_W = 8,
  parameter int DIM = 16
);
  logic                                 I_VLD;
  logic [0:DIM-1][0:DIM-1][D_W-1:0]     I_SCORE;
  logic                                 I_CAUSAL;
  logic                                 O_READY;
  logic                                 O_VLD;
  logic [0:DIM-1][0:DIM-1][D_W-1:0]     O_PROB;

  modport master (
    output I_VLD, I_SCORE, I_CAUSAL,
    input  O_READY, O_VLD, O_PROB
  );

  modport slave (
    input  I_VLD, I_SCORE, I_CAUSAL,
    output O_READY, O_VLD, O_PROB
  );
endinterface

// File: rtl/attn_softmax.sv
// Row-wise fixed-point softmax over a DIMxDIM score tile: max scan, 2^-d weights,
// then one shared 8-step restoring divider producing Q0.7 probabilities.
module attn_softmax #(
  parameter int D_W      = 8,
  parameter int DIM      = 16,
  parameter int SCALE_SH = 0
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  attn_softmax_if.slave bus
);

  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int SW = 8 + IW;

  typedef enum logic [2:0] {S_IDLE, S_MAX, S_EXP, S_DIV, S_DONE} state_t;

  state_t                 state;
  logic signed [D_W-1:0]  sbuf [DIM][DIM];
  logic [7:0]             wbuf [DIM];
  logic                   causal;
  logic [IW-1:0]          row, col;
  logic [2:0]             bitc;
  logic signed [D_W-1:0]  m;
  logic [SW-1:0]          sum;
  logic [SW-1:0]          rem;
  logic [6:0]             quo;

  logic signed [D_W-1:0]  s_cur;
  logic                   valid_cur;
  logic [D_W:0]           d;
  logic [7:0]             w_cur;
  logic [SW-1:0]          rem_in;
  logic                   nbit;
  logic [SW:0]            trial;
  logic [SW-1:0]          rem_nxt;
  logic                   qb;
  logic [7:0]             quo_nxt;
  logic [D_W-1:0]         prob_val;
  logic                   last_col;

  always_comb begin
    s_cur     = sbuf[row][col];
    valid_cur = !causal || (col <= row);
    last_col  = (col == IW'(DIM - 1));
    d         = {m[D_W-1], m} - {s_cur[D_W-1], s_cur};
    w_cur     = 8'd0;
    if (valid_cur && (d < (D_W + 1)'(8)))
      w_cur = 8'hFF >> d[2:0];

    // Dividend is w<<7; seeding the remainder with w>>1 leaves exactly 8 quotient bits.
    rem_in  = (bitc == 3'd0) ? {{(SW - 7){1'b0}}, wbuf[col][7:1]} : rem;
    nbit    = (bitc == 3'd0) ? wbuf[col][0] : 1'b0;
    trial   = {rem_in, nbit};
    qb      = 1'b0;
    rem_nxt = trial[SW-1:0];
    if (trial >= {1'b0, sum}) begin
      qb      = 1'b1;
      rem_nxt = SW'(trial - {1'b0, sum});
    end
    quo_nxt  = {quo, qb};
    prob_val = '0;
    prob_val[6:0] = quo_nxt[7] ? 7'd127 : quo_nxt[6:0];
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state      <= S_IDLE;
      bus.O_READY <= 1'b1;
      bus.O_VLD  <= 1'b0;
      bus.O_PROB <= '0;
      causal     <= 1'b0;
      row        <= '0;
      col        <= '0;
      bitc       <= '0;
      m          <= '0;
      sum        <= '0;
      rem        <= '0;
      quo        <= '0;
      for (int unsigned r = 0; r < DIM; r++) begin
        wbuf[r] <= '0;
        for (int unsigned c = 0; c < DIM; c++)
          sbuf[r][c] <= '0;
      end
    end else begin
      bus.O_VLD <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.I_VLD) begin
            for (int unsigned r = 0; r < DIM; r++)
              for (int unsigned c = 0; c < DIM; c++)
                sbuf[r][c] <= $signed(bus.I_SCORE[r][c]) >>> SCALE_SH;
            causal      <= bus.I_CAUSAL;
            row         <= '0;
            col         <= '0;
            bus.O_READY <= 1'b0;
            state       <= S_MAX;
          end
        end
        S_MAX: begin
          if (col == '0)
            m <= s_cur;
          else if (valid_cur && (s_cur > m))
            m <= s_cur;
          if (last_col) begin
            col   <= '0;
            sum   <= '0;
            state <= S_EXP;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_EXP: begin
          wbuf[col] <= w_cur;
          sum       <= sum + SW'(w_cur);
          if (last_col) begin
            col   <= '0;
            bitc  <= '0;
            state <= S_DIV;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_DIV: begin
          rem  <= rem_nxt;
          quo  <= quo_nxt[6:0];
          bitc <= bitc + 3'd1;
          if (bitc == 3'd7) begin
            bus.O_PROB[row][col] <= prob_val;
            if (last_col) begin
              col <= '0;
              if (row == IW'(DIM - 1)) begin
                state <= S_DONE;
              end else begin
                row   <= row + 1'b1;
                state <= S_MAX;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DONE: begin
          bus.O_VLD   <= 1'b1;
          bus.O_READY <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_attn_softmax.sv
// Directed bench for attn_softmax: reference softmax model feeds a scoreboard queue,
// each result tile and latency is checked with immediate assertions.
module tb_attn_softmax;

  typedef logic [0:15][0:15][7:0] tile_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  attn_softmax_if #(.D_W(8), .DIM(16)) bus0 ();
  attn_softmax_if #(.D_W(8), .DIM(16)) bus1 ();

  attn_softmax #(.D_W(8), .DIM(16), .SCALE_SH(0)) dut0 (.I_CLK(clk), .I_RST(rst0), .bus(bus0));
  attn_softmax #(.D_W(8), .DIM(16), .SCALE_SH(3)) dut1 (.I_CLK(clk), .I_RST(rst1), .bus(bus1));

  int    n_checks = 0;
  int    n_fails  = 0;
  tile_t exp_q[$];

  function automatic tile_t model(input tile_t sc, input logic cz, input int sh);
    tile_t p;
    logic signed [7:0] e;
    int s [16];
    int w [16];
    int mx, tot, q;
    p = '0;
    for (int r = 0; r < 16; r++) begin
      mx = -100000;
      for (int c = 0; c < 16; c++) begin
        e = sc[r][c];
        s[c] = e;
        s[c] = s[c] >>> sh;
        if ((!cz || c <= r) && s[c] > mx) mx = s[c];
      end
      tot = 0;
      for (int c = 0; c < 16; c++) begin
        w[c] = 0;
        if ((!cz || c <= r) && (mx - s[c]) < 8) w[c] = 255 >> (mx - s[c]);
        tot += w[c];
      end
      for (int c = 0; c < 16; c++) begin
        q = (w[c] * 128) / tot;
        if (q > 127) q = 127;
        p[r][c] = 8'(q);
      end
    end
    return p;
  endfunction

  function automatic tile_t get_prob(input int sel);
    return (sel == 1) ? bus1.O_PROB : bus0.O_PROB;
  endfunction

  function automatic int get_vld(input int sel);
    return (sel == 1) ? int'(bus1.O_VLD) : int'(bus0.O_VLD);
  endfunction

  function automatic int get_ready(input int sel);
    return (sel == 1) ? int'(bus1.O_READY) : int'(bus0.O_READY);
  endfunction

  task automatic drive(input int sel, input logic vld, input tile_t sc, input logic cz);
    if (sel == 1) begin
      bus1.I_VLD = vld; bus1.I_SCORE = sc; bus1.I_CAUSAL = cz;
    end else begin
      bus0.I_VLD = vld; bus0.I_SCORE = sc; bus0.I_CAUSAL = cz;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tile(input string tag, input tile_t obs, input tile_t exp);
    int fr, fc;
    fr = -1; fc = 0;
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          if (fr < 0 && obs[r][c] !== exp[r][c]) begin fr = r; fc = c; end
      if (fr < 0) fr = 0;
      $error("FAIL %s: prob[%0d][%0d] observed %0d expected %0d", tag, fr, fc, obs[fr][fc], exp[fr][fc]);
    end
  endtask

  task automatic send(input int sel, input tile_t sc, input logic cz, input string tag);
    @(negedge clk);
    chk({tag, " ready_before"}, get_ready(sel), 1);
    exp_q.push_back(model(sc, cz, (sel == 1) ? 3 : 0));
    drive(sel, 1'b1, sc, cz);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, sc, cz);
    chk({tag, " ready_drop"}, get_ready(sel), 0);
  endtask

  task automatic wait_done(input int sel, input string tag, input bit poke, output tile_t res);
    int    n;
    bit    seen;
    tile_t ex, junk;
    junk = {256{8'h7F}};
    n = 0; seen = 1'b0;
    while (!seen && n < 3000) begin
      @(posedge clk); #1; n++;
      if (poke && n == 500) drive(sel, 1'b1, junk, 1'b0);
      if (poke && n == 501) drive(sel, 1'b0, junk, 1'b0);
      if (get_vld(sel) == 1) seen = 1'b1;
    end
    chk({tag, " latency"}, seen ? n : 0, 2561);
    res = get_prob(sel);
    chk({tag, " scoreboard_nonempty"}, int'(exp_q.size() > 0), 1);
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk_tile({tag, " tile"}, res, ex);
    @(posedge clk); #1;
    chk({tag, " vld_pulse_end"}, get_vld(sel), 0);
    chk({tag, " ready_after"}, get_ready(sel), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tile_t t, res;
    int    cnt, rs;

    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("reset ready", get_ready(0), 1);
    chk("reset vld", get_vld(0), 0);
    chk("reset prob_zero", int'(get_prob(0) == '0), 1);
    chk("reset ready dut1", get_ready(1), 1);

    // All zeros, no mask: every probability 8
    t = '0;
    send(0, t, 1'b0, "zeros");
    wait_done(0, "zeros", 1'b0, res);
    chk("zeros p00", int'(res[0][0]), 8);
    chk("zeros p15_15", int'(res[15][15]), 8);
    chk("zeros p7_3", int'(res[7][3]), 8);
    cnt = 0;
    for (int r = 0; r < 16; r++) begin
      rs = 0;
      for (int c = 0; c < 16; c++) rs += int'(res[r][c]);
      if (rs <= 128 && rs >= 112) cnt++;
    end
    chk("zeros rowsum_range", cnt, 16);

    // One dominant score: saturation at 127
    t = '0; t[0][0] = 8'd100;
    send(0, t, 1'b0, "dominant");
    wait_done(0, "dominant", 1'b0, res);
    chk("dominant p00", int'(res[0][0]), 127);
    chk("dominant p01", int'(res[0][1]), 0);
    chk("dominant p1_0", int'(res[1][0]), 8);

    // Two close scores plus far-negative tail
    t = '0;
    for (int c = 2; c < 16; c++) t[0][c] = 8'h80;
    t[0][0] = 8'd10; t[0][1] = 8'd9;
    send(0, t, 1'b0, "pair");
    wait_done(0, "pair", 1'b0, res);
    chk("pair p00", int'(res[0][0]), 85);
    chk("pair p01", int'(res[0][1]), 42);
    chk("pair p02", int'(res[0][2]), 0);
    chk("pair p15", int'(res[0][15]), 0);
    chk("pair p1_5", int'(res[1][5]), 8);

    // Causal mask on zeros
    t = '0;
    send(0, t, 1'b1, "causal");
    wait_done(0, "causal", 1'b0, res);
    chk("causal p0_0", int'(res[0][0]), 127);
    chk("causal p0_1", int'(res[0][1]), 0);
    chk("causal p1_0", int'(res[1][0]), 64);
    chk("causal p1_1", int'(res[1][1]), 64);
    chk("causal p1_2", int'(res[1][2]), 0);
    chk("causal p2_2", int'(res[2][2]), 42);
    chk("causal p3_3", int'(res[3][3]), 32);
    chk("causal p4_10", int'(res[4][10]), 0);
    chk("causal p15_15", int'(res[15][15]), 8);

    // Scaled instance with a mid-tile I_VLD that must be ignored
    t = '0; t[0][0] = 8'd64;
    send(1, t, 1'b0, "scaled");
    wait_done(1, "scaled", 1'b1, res);
    chk("scaled p00", int'(res[0][0]), 127);
    chk("scaled p01", int'(res[0][1]), 0);
    chk("scaled p5_5", int'(res[5][5]), 8);
    cnt = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (get_vld(1) == 1) cnt++;
    end
    chk("scaled extra_vld", cnt, 0);

    // Reset 1000 cycles into a tile aborts it
    t = '0; t[3][2] = 8'd50;
    send(0, t, 1'b0, "abort");
    repeat (1000) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    chk("abort ready", get_ready(0), 1);
    chk("abort vld", get_vld(0), 0);
    chk("abort prob_zero", int'(get_prob(0) == '0), 1);
    cnt = 0;
    repeat (2700) begin
      @(posedge clk); #1;
      if (get_vld(0) == 1) cnt++;
    end
    chk("abort no_vld", cnt, 0);

    t = '0; t[0][0] = 8'd100;
    send(0, t, 1'b0, "post_reset");
    wait_done(0, "post_reset", 1'b0, res);
    chk("post_reset p00", int'(res[0][0]), 127);
    chk("post_reset p9_9", int'(res[9][9]), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
